serializador: RTL

Transmit-side counterpart of the team's bit-serial link. Accepts 8-bit words from the stack side through a 2-entry word FIFO and shifts each one out LSB-first as a bit stream with a per-bit valid strobe, pacing itself against the downstream deserializer's busy indication. After every word it waits for the receiver's busy/ack cycle before sending the next word, so that word boundaries stay aligned.

---
 rtl/serial_pkg.sv | 13 +
 rtl/serializador_if.sv | 25 ++
 rtl/serial_fifo.sv | 42 ++++
 rtl/serializador.sv | 104 ++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and constants for the bit-serial link
package serial_pkg;

    localparam int WORD_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT_HI,
        WAIT_LO
    } state_t;

endpackage

// File: rtl/serializador_if.sv
// rtl/serializador_if.sv - word-in / bit-out handshake bundle of the serializer
interface serializador_if
    import serial_pkg::*;
#(
    parameter int WIDTH = WORD_W
);
    logic [WIDTH-1:0] data_in;
    logic             write_in;
    logic             status_out;
    logic             overflow_out;
    logic             data_out;
    logic             write_out;
    logic             busy_in;
    logic             word_done;

    modport master (
        output data_in, write_in, busy_in,
        input  status_out, overflow_out, data_out, write_out, word_done
    );

    modport slave (
        input  data_in, write_in, busy_in,
        output status_out, overflow_out, data_out, write_out, word_done
    );
endinterface

// File: rtl/serial_fifo.sv
// rtl/serial_fifo.sv - small word FIFO with wrap-bit pointers
module serial_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr, rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Extra MSB on each pointer distinguishes full from empty when indices match
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign dout  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/serializador.sv
// rtl/serializador.sv - FIFO-buffered LSB-first word serializer paced by receiver busy
module serializador
    import serial_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           reset,
    serializador_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nx;
    logic [CW-1:0]    idx, idx_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic             data_r, data_nx;
    logic             wr_r, wr_nx;
    logic             done_r, done_nx;
    logic             ovf_r;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_full, fifo_empty, pop;

    assign pop = (state == IDLE) && !fifo_empty && !bus.busy_in;

    serial_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.write_in),
        .pop   (pop),
        .din   (bus.data_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The shift register holds the not-yet-sent bits, so the next bit is always shreg[0]
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        shreg_nx = shreg;
        data_nx  = data_r;
        wr_nx    = 1'b0;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (pop) begin
                    shreg_nx = fifo_dout >> 1;
                    data_nx  = fifo_dout[0];
                    wr_nx    = 1'b1;
                    idx_nx   = CW'(1);
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (idx == CW'(WIDTH)) begin
                    state_nx = WAIT_HI;
                end else if (!bus.busy_in) begin
                    data_nx  = shreg[0];
                    shreg_nx = shreg >> 1;
                    wr_nx    = 1'b1;
                    idx_nx   = idx + CW'(1);
                end
            end
            WAIT_HI: begin
                if (bus.busy_in) state_nx = WAIT_LO;
            end
            WAIT_LO: begin
                if (!bus.busy_in) begin
                    done_nx  = 1'b1;
                    idx_nx   = '0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= '0;
            shreg  <= '0;
            data_r <= 1'b0;
            wr_r   <= 1'b0;
            done_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            shreg  <= shreg_nx;
            data_r <= data_nx;
            wr_r   <= wr_nx;
            done_r <= done_nx;
            if (bus.write_in && fifo_full) ovf_r <= 1'b1;
        end
    end

    assign bus.status_out   = fifo_full;
    assign bus.overflow_out = ovf_r;
    assign bus.data_out     = data_r;
    assign bus.write_out    = wr_r;
    assign bus.word_done    = done_r;
endmodule
